crop_sequencer: RTL and testbench

CROP_SEQUENCER -- requirements
Module: crop_sequencer

---
 rtl/crop_sequencer_if.sv | 36 +++
 rtl/crop_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_crop_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/crop_sequencer_if.sv
// Stream bundle for crop_sequencer: {Y1,X1} request input plus the Y1/X1 coordinate outputs.
// The slave modport is the sequencer's view; the master modport is the upstream/downstream view.
interface crop_sequencer_if #(
    parameter int ROW_W = 10,
    parameter int COL_W = 10
);
    logic [ROW_W+COL_W-1:0] req_TDATA;
    logic                   req_TVALID;
    logic                   req_TREADY;

    logic [ROW_W-1:0]       crop_Y1_TDATA;
    logic                   crop_Y1_TVALID;
    logic                   crop_Y1_TREADY;

    logic [COL_W-1:0]       crop_X1_TDATA;
    logic                   crop_X1_TVALID;
    logic                   crop_X1_TREADY;

    modport slave (
        input  req_TDATA, req_TVALID,
        output req_TREADY,
        output crop_Y1_TDATA, crop_Y1_TVALID,
        input  crop_Y1_TREADY,
        output crop_X1_TDATA, crop_X1_TVALID,
        input  crop_X1_TREADY
    );

    modport master (
        output req_TDATA, req_TVALID,
        input  req_TREADY,
        input  crop_Y1_TDATA, crop_Y1_TVALID,
        output crop_Y1_TREADY,
        input  crop_X1_TDATA, crop_X1_TVALID,
        output crop_X1_TREADY
    );
endinterface

// File: rtl/crop_sequencer.sv
// Frame-level crop sequencer: buffers {Y1,X1} requests, launches the crop core once per crop.
// Optional feature: define CROP_CLAMP_EN to clamp popped coordinates so the crop stays in-image.
module crop_sequencer #(
    parameter int IN_ROWS          = 100,
    parameter int IN_COLS          = 160,
    parameter int OUT_ROWS         = 48,
    parameter int OUT_COLS         = 48,
    parameter int IMG_ROW_BITWIDTH = 10,
    parameter int IMG_COL_BITWIDTH = 10,
    parameter int REQ_DEPTH        = 4
) (
    input  logic       ap_clk,
    input  logic       ap_rst_n,
    input  logic       ap_start,
    input  logic [2:0] n_crops,
    output logic       ap_done,
    output logic       ap_idle,
    output logic       ap_ready,
    output logic       core_start,
    input  logic       core_done,
    output logic [2:0] crop_count,
    crop_sequencer_if.slave bus
);
    localparam int RW = IMG_ROW_BITWIDTH;
    localparam int CW = IMG_COL_BITWIDTH;
    localparam int AW = $clog2(REQ_DEPTH);
    localparam logic [AW:0] DEPTH_P = (AW+1)'(REQ_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_REQ, S_LAUNCH, S_SEND, S_WAIT_DONE, S_FINISH
    } state_t;

    state_t            r_state;
    logic [RW+CW-1:0]  r_fifo_mem [REQ_DEPTH];
    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic [RW-1:0]     r_y1;
    logic [CW-1:0]     r_x1;
    logic              r_y_valid;
    logic              r_x_valid;
    logic              r_core_start;
    logic              r_ap_done;
    logic              r_ap_idle;
    logic              r_ap_ready;
    logic              r_done_latched;
    logic [2:0]        r_n_crops;
    logic [2:0]        r_crop_count;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic [RW-1:0]     w_head_y;
    logic [CW-1:0]     w_head_x;
    logic [RW-1:0]     w_pop_y;
    logic [CW-1:0]     w_pop_x;
    logic              w_y_hs;
    logic              w_x_hs;
    logic              w_y_clear;
    logic              w_x_clear;
    logic              w_done_seen;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_full  = (r_wr_ptr - r_rd_ptr) == DEPTH_P;
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_push  = bus.req_TVALID && !w_full;
    assign w_pop   = (r_state == S_WAIT_REQ) && !w_empty;

    assign w_head_y = r_fifo_mem[r_rd_ptr[AW-1:0]][CW +: RW];
    assign w_head_x = r_fifo_mem[r_rd_ptr[AW-1:0]][CW-1:0];

`ifdef CROP_CLAMP_EN
    localparam logic [RW-1:0] MAX_Y = RW'(IN_ROWS - OUT_ROWS);
    localparam logic [CW-1:0] MAX_X = CW'(IN_COLS - OUT_COLS);
    assign w_pop_y = (w_head_y > MAX_Y) ? MAX_Y : w_head_y;
    assign w_pop_x = (w_head_x > MAX_X) ? MAX_X : w_head_x;
`else
    assign w_pop_y = w_head_y;
    assign w_pop_x = w_head_x;
`endif

    // A channel counts as finished once its valid is low after this edge.
    assign w_y_hs      = r_y_valid && bus.crop_Y1_TREADY;
    assign w_x_hs      = r_x_valid && bus.crop_X1_TREADY;
    assign w_y_clear   = !r_y_valid || bus.crop_Y1_TREADY;
    assign w_x_clear   = !r_x_valid || bus.crop_X1_TREADY;
    assign w_done_seen = core_done || r_done_latched;

    always_ff @(posedge ap_clk) begin
        if (w_push) begin
            r_fifo_mem[r_wr_ptr[AW-1:0]] <= bus.req_TDATA;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state        <= S_IDLE;
            r_y1           <= '0;
            r_x1           <= '0;
            r_y_valid      <= 1'b0;
            r_x_valid      <= 1'b0;
            r_core_start   <= 1'b0;
            r_ap_done      <= 1'b0;
            r_ap_idle      <= 1'b1;
            r_ap_ready     <= 1'b1;
            r_done_latched <= 1'b0;
            r_n_crops      <= '0;
            r_crop_count   <= '0;
        end else begin
            r_core_start <= 1'b0;
            r_ap_done    <= 1'b0;
            if (w_y_hs) r_y_valid <= 1'b0;
            if (w_x_hs) r_x_valid <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (ap_start) begin
                        r_n_crops      <= n_crops;
                        r_crop_count   <= '0;
                        r_done_latched <= 1'b0;
                        r_ap_idle      <= 1'b0;
                        r_ap_ready     <= 1'b0;
                        if (n_crops == 3'd0) begin
                            r_state   <= S_FINISH;
                            r_ap_done <= 1'b1;
                        end else begin
                            r_state <= S_WAIT_REQ;
                        end
                    end
                end
                S_WAIT_REQ: begin
                    if (!w_empty) begin
                        r_y1         <= w_pop_y;
                        r_x1         <= w_pop_x;
                        r_core_start <= 1'b1;
                        r_y_valid    <= 1'b1;
                        r_x_valid    <= 1'b1;
                        r_state      <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    // The core may answer as soon as it sees core_start.
                    if (core_done) r_done_latched <= 1'b1;
                    r_state <= S_SEND;
                end
                S_SEND: begin
                    if (core_done) r_done_latched <= 1'b1;
                    if (w_y_clear && w_x_clear) r_state <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (w_done_seen) begin
                        r_done_latched <= 1'b0;
                        r_crop_count   <= r_crop_count + 3'd1;
                        if (r_crop_count + 3'd1 == r_n_crops) begin
                            r_state   <= S_FINISH;
                            r_ap_done <= 1'b1;
                        end else begin
                            r_state <= S_WAIT_REQ;
                        end
                    end
                end
                S_FINISH: begin
                    r_state    <= S_IDLE;
                    r_ap_idle  <= 1'b1;
                    r_ap_ready <= 1'b1;
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_ap_idle  <= 1'b1;
                    r_ap_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_TREADY     = !w_full;
    assign bus.crop_Y1_TDATA  = r_y1;
    assign bus.crop_Y1_TVALID = r_y_valid;
    assign bus.crop_X1_TDATA  = r_x1;
    assign bus.crop_X1_TVALID = r_x_valid;
    assign core_start         = r_core_start;
    assign ap_done            = r_ap_done;
    assign ap_idle            = r_ap_idle;
    assign ap_ready           = r_ap_ready;
    assign crop_count         = r_crop_count;
endmodule

// File: tb/tb_crop_sequencer.sv
// Scoreboard bench for crop_sequencer: accepted requests queue expected coordinates,
// delivered Y1/X1 handshakes pop and compare; frame-level counters checked per frame.
module tb_crop_sequencer;
    logic       ap_clk = 1'b0;
    logic       ap_rst_n = 1'b0;
    logic       ap_start = 1'b0;
    logic [2:0] n_crops = 3'd0;
    logic       ap_done;
    logic       ap_idle;
    logic       ap_ready;
    logic       core_start;
    logic       core_done = 1'b0;
    logic [2:0] crop_count;

    crop_sequencer_if #(.ROW_W(10), .COL_W(10)) bus ();

    crop_sequencer dut (
        .ap_clk     (ap_clk),
        .ap_rst_n   (ap_rst_n),
        .ap_start   (ap_start),
        .n_crops    (n_crops),
        .ap_done    (ap_done),
        .ap_idle    (ap_idle),
        .ap_ready   (ap_ready),
        .core_start (core_start),
        .core_done  (core_done),
        .crop_count (crop_count),
        .bus        (bus)
    );

    always #5 ap_clk = ~ap_clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] model_y(input logic [9:0] y);
`ifdef CROP_CLAMP_EN
        return (y > 10'd52) ? 10'd52 : y;
`else
        return y;
`endif
    endfunction

    function automatic logic [9:0] model_x(input logic [9:0] x);
`ifdef CROP_CLAMP_EN
        return (x > 10'd112) ? 10'd112 : x;
`else
        return x;
`endif
    endfunction

    logic [9:0] exp_y[$];
    logic [9:0] exp_x[$];
    int  acc_cnt   = 0;
    int  start_cnt = 0;
    int  done_cnt  = 0;
    int  rdy_mode  = 0;
    int  done_dly  = 3;
    bit  done_rand = 1'b0;
    bit  ok;
    bit  ok5;

    bit         y_pend = 1'b0;
    bit         x_pend = 1'b0;
    logic [9:0] y_hold = '0;
    logic [9:0] x_hold = '0;

    // Monitor: scoreboard push on request accept, pop/compare on each coordinate handshake.
    always @(negedge ap_clk) begin
        if (!ap_rst_n) begin
            y_pend = 1'b0;
            x_pend = 1'b0;
        end else begin
            if (bus.req_TVALID && bus.req_TREADY) begin
                exp_y.push_back(model_y(bus.req_TDATA[19:10]));
                exp_x.push_back(model_x(bus.req_TDATA[9:0]));
                acc_cnt++;
            end
            if (core_start) start_cnt++;
            if (ap_done)    done_cnt++;
            if (y_pend) check_eq("y1_hold", {bus.crop_Y1_TVALID, bus.crop_Y1_TDATA}, {1'b1, y_hold});
            if (x_pend) check_eq("x1_hold", {bus.crop_X1_TVALID, bus.crop_X1_TDATA}, {1'b1, x_hold});
            if (bus.crop_Y1_TVALID && bus.crop_Y1_TREADY) begin
                check_eq("y1_expected", exp_y.size() != 0, 1);
                if (exp_y.size() != 0) check_eq("y1_data", bus.crop_Y1_TDATA, exp_y.pop_front());
            end
            if (bus.crop_X1_TVALID && bus.crop_X1_TREADY) begin
                check_eq("x1_expected", exp_x.size() != 0, 1);
                if (exp_x.size() != 0) check_eq("x1_data", bus.crop_X1_TDATA, exp_x.pop_front());
            end
            y_pend = bus.crop_Y1_TVALID && !bus.crop_Y1_TREADY;
            x_pend = bus.crop_X1_TVALID && !bus.crop_X1_TREADY;
            y_hold = bus.crop_Y1_TDATA;
            x_hold = bus.crop_X1_TDATA;
        end
    end

    initial begin
        bus.crop_Y1_TREADY = 1'b1;
        bus.crop_X1_TREADY = 1'b1;
        forever begin
            @(posedge ap_clk);
            #1;
            case (rdy_mode)
                0: begin bus.crop_Y1_TREADY = 1'b1; bus.crop_X1_TREADY = 1'b1; end
                1: begin
                    bus.crop_Y1_TREADY = 1'($urandom_range(0, 1));
                    bus.crop_X1_TREADY = 1'($urandom_range(0, 1));
                end
                default: begin bus.crop_Y1_TREADY = 1'b0; bus.crop_X1_TREADY = 1'b0; end
            endcase
        end
    end

    // Crop core model: one core_done pulse a configurable number of cycles after core_start.
    initial begin
        int d;
        forever begin
            @(negedge ap_clk);
            if (core_start && ap_rst_n) begin
                d = done_rand ? int'($urandom_range(1, 6)) : done_dly;
                repeat (d) @(posedge ap_clk);
                #1 core_done = 1'b1;
                @(posedge ap_clk);
                #1 core_done = 1'b0;
            end
        end
    end

    task automatic push_req(input logic [9:0] y, input logic [9:0] x, input int bound, output bit acc);
        int base;
        acc = 1'b0;
        @(posedge ap_clk);
        #1;
        bus.req_TDATA  = {y, x};
        bus.req_TVALID = 1'b1;
        base = acc_cnt;
        for (int i = 0; i < bound; i++) begin
            @(posedge ap_clk);
            #1;
            if (acc_cnt != base) begin
                acc = 1'b1;
                break;
            end
        end
        bus.req_TVALID = 1'b0;
        $display("push (%0d,%0d) accepted=%0d", y, x, acc);
    endtask

    task automatic run_frame(input logic [2:0] n, input int bound, input int left);
        int s0;
        int d0;
        bit seen;
        s0   = start_cnt;
        d0   = done_cnt;
        seen = 1'b0;
        @(posedge ap_clk);
        #1;
        n_crops  = n;
        ap_start = 1'b1;
        @(posedge ap_clk);
        #1;
        ap_start = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(posedge ap_clk);
            #1;
            if (done_cnt != d0) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq("frame_done_seen", seen, 1);
        repeat (3) @(posedge ap_clk);
        #1;
        check_eq("ap_done_pulses", done_cnt - d0, 1);
        check_eq("core_starts", start_cnt - s0, 32'(n));
        check_eq("crop_count", crop_count, 32'(n));
        check_eq("ap_idle", ap_idle, 1);
        check_eq("sb_y_left", exp_y.size(), left);
        check_eq("sb_x_left", exp_x.size(), left);
        $display("frame n_crops=%0d done=%0d core_starts=%0d crop_count=%0d",
                 n, seen, start_cnt - s0, crop_count);
    endtask

    initial begin
        int base;
        bit seen;
        bus.req_TVALID = 1'b0;
        bus.req_TDATA  = '0;

        // Reset state
        #12;
        check_eq("rst_ap_idle", ap_idle, 1);
        check_eq("rst_ap_ready", ap_ready, 1);
        check_eq("rst_ap_done", ap_done, 0);
        check_eq("rst_core_start", core_start, 0);
        check_eq("rst_y_valid", bus.crop_Y1_TVALID, 0);
        check_eq("rst_x_valid", bus.crop_X1_TVALID, 0);
        check_eq("rst_crop_count", crop_count, 0);
        check_eq("rst_req_tready", bus.req_TREADY, 1);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;

        // Single crop, core_done three cycles after core_start
        push_req(10'd10, 10'd10, 4, ok);
        check_eq("t1_accept", ok, 1);
        run_frame(3'd1, 100, 0);

        // Four crops with random ready/core latency and a stray ap_start mid-frame
        rdy_mode  = 1;
        done_rand = 1'b1;
        for (int k = 0; k < 4; k++) begin
            push_req(10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)), 4, ok);
            check_eq("t2_accept", ok, 1);
        end
        fork
            run_frame(3'd4, 1000, 0);
            begin
                repeat (8) @(posedge ap_clk);
                #1;
                n_crops  = 3'd1;
                ap_start = 1'b1;
                @(posedge ap_clk);
                #1;
                ap_start = 1'b0;
            end
        join

        // Zero-crop frame
        rdy_mode  = 0;
        done_rand = 1'b0;
        run_frame(3'd0, 6, 0);

        // FIFO full: fifth request waits for the first pop
        base = acc_cnt;
        for (int k = 0; k < 4; k++) begin
            push_req(10'(30 + k), 10'(40 + k), 4, ok);
            check_eq("t4_accept", ok, 1);
        end
        check_eq("t4_tready_full", bus.req_TREADY, 0);
        fork
            push_req(10'd99, 10'd98, 100, ok5);
            begin
                repeat (5) @(posedge ap_clk);
                #1;
                check_eq("t4_fifth_held", acc_cnt - base, 4);
                run_frame(3'd1, 100, 4);
            end
        join
        check_eq("t4_fifth_accepted", ok5, 1);
        rdy_mode = 1;
        run_frame(3'd4, 500, 0);
        rdy_mode = 0;

        // Reset while in SEND
        push_req(10'd5, 10'd6, 4, ok);
        push_req(10'd7, 10'd8, 4, ok);
        rdy_mode = 2;
        @(posedge ap_clk);
        #1;
        n_crops  = 3'd1;
        ap_start = 1'b1;
        @(posedge ap_clk);
        #1;
        ap_start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge ap_clk);
            #1;
            if (bus.crop_Y1_TVALID) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq("t5_launch_seen", seen, 1);
        @(posedge ap_clk);
        @(negedge ap_clk);
        #2;
        ap_rst_n = 1'b0;
        #1;
        check_eq("t5_y_valid", bus.crop_Y1_TVALID, 0);
        check_eq("t5_x_valid", bus.crop_X1_TVALID, 0);
        check_eq("t5_crop_count", crop_count, 0);
        check_eq("t5_ap_idle", ap_idle, 1);
        check_eq("t5_ap_ready", ap_ready, 1);
        check_eq("t5_req_tready", bus.req_TREADY, 1);
        check_eq("t5_y_data", bus.crop_Y1_TDATA, 0);
        $display("reset in SEND: y_valid=%0d crop_count=%0d ap_idle=%0d",
                 bus.crop_Y1_TVALID, crop_count, ap_idle);
        exp_y.delete();
        exp_x.delete();
        rdy_mode = 0;
        repeat (2) @(posedge ap_clk);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        repeat (10) @(posedge ap_clk);
        // Stale FIFO entries would surface here as a scoreboard mismatch.
        push_req(10'd20, 10'd30, 4, ok);
        run_frame(3'd1, 100, 0);

        // Coordinates past the clamp limits, and exactly at them
        push_req(10'd90, 10'd150, 4, ok);
        push_req(10'd52, 10'd112, 4, ok);
        run_frame(3'd2, 200, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end
endmodule
